// File: rtl/maluma_pkg.sv
// Shared definitions for the mALUma issue queue: opcodes, flag layout,
// canonical NaN encodings and the issue FSM state type.
package maluma_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_INEXACT   = 4;

    localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] HP_QNAN = 32'h0000_7E00;

    // A hung ALU is reported as an invalid operation producing a quiet NaN.
    localparam logic [4:0] TIMEOUT_FLAGS = 5'(1 << FLAG_INVALID);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [31:0] canon_nan(input logic mode_fp);
        return mode_fp ? SP_QNAN : HP_QNAN;
    endfunction

endpackage

// File: rtl/maluma_cmd_fifo.sv
// Small synchronous show-ahead FIFO holding packed commands. Pointers carry
// an extra wrap bit so full and empty are distinguishable without a counter.
module maluma_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance with synchronous reset discarding any queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/maluma_issue_queue.sv
// Issue queue in front of the mALUma FP ALU: buffers commands, issues one at
// a time, returns tagged results with sticky exception flags and a watchdog.
module maluma_issue_queue
    import maluma_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_mode,
    input  logic             cmd_round,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_start,
    output logic [31:0]      alu_op_a,
    output logic [31:0]      alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_mode_fp,
    output logic             alu_round_mode,
    input  logic [31:0]      alu_result,
    input  logic             alu_valid_out,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic [4:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic             busy
);
    localparam int CMD_W = TAG_W + 2 + 3 + 64;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CMD_W-1:0] push_data;
    logic [CMD_W-1:0] head_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic [31:0]      a_store;
    logic [31:0]      b_store;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             timed_out;
    logic             rsp_fire;

    // Half-precision operands live in the low half; the upper half is zeroed on entry.
    assign a_store   = cmd_mode ? cmd_a : {16'h0000, cmd_a[15:0]};
    assign b_store   = cmd_mode ? cmd_b : {16'h0000, cmd_b[15:0]};
    assign push_data = {cmd_tag, cmd_round, cmd_mode, cmd_op, b_store, a_store};

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign timed_out = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign busy      = !fifo_empty || (state_reg != ST_IDLE);

    maluma_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state selection; valid_out is only honoured once in WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!fifo_empty) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (alu_valid_out || timed_out) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered ALU drive, watchdog counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_start      <= 1'b0;
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
            tag_reg        <= '0;
            wait_cnt_reg   <= '0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            rsp_tag        <= '0;
            rsp_timeout    <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_op_a       <= head_data[31:0];
                        alu_op_b       <= head_data[63:32];
                        alu_op_code    <= head_data[66:64];
                        alu_mode_fp    <= head_data[67];
                        alu_round_mode <= head_data[68];
                        tag_reg        <= head_data[CMD_W-1:69];
                        alu_start      <= 1'b1;
                    end
                end
                ST_ISSUE: wait_cnt_reg <= '0;
                ST_WAIT: begin
                    if (alu_valid_out) begin
                        rsp_result  <= alu_mode_fp ? alu_result : {16'h0000, alu_result[15:0]};
                        rsp_flags   <= alu_flags;
                        rsp_tag     <= tag_reg;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else if (timed_out) begin
                        rsp_result  <= canon_nan(alu_mode_fp);
                        rsp_flags   <= TIMEOUT_FLAGS;
                        rsp_tag     <= tag_reg;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Sticky exception flags; a clear coinciding with a handshake keeps that response's flags.
    always_ff @(posedge clk) begin
        if (rst)                       sticky_flags <= '0;
        else if (rsp_fire && sticky_clr) sticky_flags <= rsp_flags;
        else if (rsp_fire)             sticky_flags <= sticky_flags | rsp_flags;
        else if (sticky_clr)           sticky_flags <= '0;
    end

endmodule

// File: doc/maluma_issue_queue.md
Name: maluma_issue_queue

Overview:
Command front-end that sits directly upstream of the mALUma IEEE-754 ALU. It buffers FP operation requests in a FIFO and issues them one at a time using the ALU's start/valid_out handshake. It returns each result with its request tag over a ready/valid response port and keeps sticky IEEE exception flags. It isolates callers from the ALU's variable multi-cycle latency and supports hang detection.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the caller tag carried from command to response
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before a forced error response

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_a  in  32  operand A (HP uses [15:0])
cmd_b  in  32  operand B (HP uses [15:0])
cmd_op  in  3  000 add, 001 sub, 010 mul, 011 div
cmd_mode  in  1  1 = single (32-bit), 0 = half (16-bit)
cmd_round  in  1  rounding mode, passed through
cmd_tag  in  TAG_W  caller tag
alu_start  out  1  one-cycle start pulse to ALU
alu_op_a, alu_op_b  out  32  operands to ALU
alu_op_code  out  3  to ALU op_code
alu_mode_fp  out  1  to ALU mode_fp
alu_round_mode  out  1  to ALU round_mode
alu_result  in  32  ALU result
alu_valid_out  in  1  ALU result valid
alu_flags  in  5  [4] inexact, [3] invalid, [2] div-by-zero, [1] overflow, [0] underflow
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts
rsp_result  out  32  result (HP: [31:16] = 0)
rsp_flags  out  5  per-op flags
rsp_tag  out  TAG_W  tag of the originating command
rsp_timeout  out  1  response was forced by timeout
sticky_flags  out  5  OR of all delivered rsp_flags
sticky_clr  in  1  clear sticky_flags
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: FIFO empty, FSM IDLE, cmd_ready=1, alu_start=0, all alu_* data outputs 0, rsp_valid=0, rsp_result/flags/tag/timeout=0, sticky_flags=0, busy=0, timeout counter 0.
- Enqueue on cmd_valid&cmd_ready. When cmd_mode=0, cmd_a[31:16] and cmd_b[31:16] are stored as 0.
- Full FIFO: cmd_ready=0 and the command is not written. Pointers are DEPTH-wrapping with an extra wrap bit. Simultaneous push and pop when full is not allowed, because ready is low.
- FSM, all outputs registered:
  IDLE: if FIFO non-empty, pop the head, load alu_op_a/b/op_code/mode_fp/round_mode and the internal tag, set alu_start=1, go to ISSUE.
  ISSUE: exactly one cycle. alu_start returns to 0 on the next edge. Clear the counter, go to WAIT.
  WAIT: alu_* data held stable. On the first cycle with alu_valid_out=1, capture alu_result (HP: upper 16 bits forced 0), alu_flags and tag into the rsp_* registers, set rsp_valid=1, rsp_timeout=0, go to RESP. A valid_out seen in ISSUE is ignored. If the counter reaches TIMEOUT_CYCLES-1 without valid_out, force the response: result = 0x7FC00000 for SP or 0x00007E00 for HP, flags = 5'b01000, rsp_timeout=1, go to RESP.
  RESP: hold rsp_* stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready, rsp_valid=0 on the next edge and go to IDLE.
- No command reordering. Only one command is outstanding at the ALU at a time.
- Issue latency: with an empty FIFO in IDLE, a command accepted at edge t gives alu_start high in cycle t+1 to t+2. A back-to-back issue after a response handshake costs one IDLE cycle.
- Sticky flags: on each response handshake, sticky_flags |= rsp_flags. If sticky_clr coincides with a handshake, sticky_flags = rsp_flags. sticky_clr alone sets sticky_flags to 0.
- Reset mid-operation: everything returns to reset values and queued commands are discarded. The bench must also reset the ALU.
- busy = FIFO non-empty | state != IDLE.

Decomposition:
- Shared package maluma_pkg holds: opcode constants (OP_ADD..OP_DIV), flag bit indices, SP/HP canonical NaN constants, and the state enum.
- One sub-module, maluma_cmd_fifo: a parameterised synchronous FIFO carrying {tag, round, mode, op, b, a}.

Test Plan:
- SP add 0x40000000 + 0x40400000, tag 3 -> one alu_start pulse; rsp_result=0x40A00000, rsp_tag=3, rsp_flags=0, rsp_timeout=0.
- HP 0xFFFF4200 + 0xFFFF4500, mode=0 -> alu_op_a=0x00004200; rsp_result=0x00004800.
- Push 5 commands back-to-back (DEPTH=4, rsp_ready=0) -> cmd_ready drops after 4 queued plus the 1 in flight. Responses come out in tag order 0..4 once rsp_ready=1, and each rsp_* is held stable while stalled.
- SP 0/0 then 5.0/0 -> rsp_flags 01000 then 00100; sticky_flags=01100. sticky_clr on the second handshake -> sticky_flags=00100.
- Stub ALU that never asserts valid_out, TIMEOUT_CYCLES=8, SP -> exactly 8 WAIT cycles, then rsp_result=0x7FC00000, rsp_flags=01000, rsp_timeout=1.
- rst asserted during WAIT with 2 commands queued -> next cycle busy=0, cmd_ready=1, rsp_valid=0, and no further alu_start.
